// File: rtl/cache_tag_array.sv
// N-way cache tag store: one sp_ram per way of {valid, dirty, tag}, 1-cycle lookup, victim pick, fill port.
// Define CACHE_TAG_PLRU_EN for per-set tree pseudo-LRU; otherwise a global round-robin pointer is used.
`ifndef CACHE_INDEX_AW
`define CACHE_INDEX_AW 8
`endif
`ifndef CACHE_TAG_WIDTH
`define CACHE_TAG_WIDTH 20
`endif

module sp_ram #(
    parameter int DW = 8,
    parameter int AW = 4
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] r_mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= wdata;
        rdata <= r_mem[addr];
    end
endmodule

module cache_tag_array #(
    parameter int WAYS     = 2,
    parameter int INDEX_AW = `CACHE_INDEX_AW,
    parameter int TAG_W    = `CACHE_TAG_WIDTH,
    parameter int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
)(
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready_o,
    input  logic                lk_valid_i,
    input  logic [INDEX_AW-1:0] lk_index_i,
    input  logic [TAG_W-1:0]    lk_tag_i,
    output logic                rsp_valid_o,
    output logic                hit_o,
    output logic [WAY_W-1:0]    hit_way_o,
    output logic                hit_dirty_o,
    output logic [WAY_W-1:0]    victim_way_o,
    output logic                victim_valid_o,
    output logic                victim_dirty_o,
    output logic [TAG_W-1:0]    victim_tag_o,
    input  logic                wr_en_i,
    input  logic [INDEX_AW-1:0] wr_index_i,
    input  logic [WAY_W-1:0]    wr_way_i,
    input  logic                wr_valid_i,
    input  logic                wr_dirty_i,
    input  logic [TAG_W-1:0]    wr_tag_i
);
    localparam int DEPTH = 1 << INDEX_AW;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [INDEX_AW-1:0] r_sweep;
    logic                r_rsp_vld;
    logic [TAG_W-1:0]    r_lk_tag;

    logic                w_lk_go, w_wr_go;
    logic [INDEX_AW-1:0] w_addr;
    entry_t              w_wdata;
    logic [WAYS-1:0]     w_we;
    entry_t [WAYS-1:0]   w_rd;
    logic                w_hit, w_all_valid;
    logic [WAY_W-1:0]    w_hit_way, w_inv_way, w_repl_way, w_victim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (&r_sweep) w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep   <= '0;
            r_rsp_vld <= 1'b0;
            r_lk_tag  <= '0;
        end else begin
            if (r_state == S_INIT) r_sweep <= r_sweep + 1'b1;
            r_rsp_vld <= w_lk_go;
            if (w_lk_go) r_lk_tag <= lk_tag_i;
        end
    end

    assign ready_o = (r_state == S_RUN);
    // A write in the same cycle owns the single RAM port; the lookup is dropped.
    assign w_wr_go = ready_o && wr_en_i;
    assign w_lk_go = ready_o && lk_valid_i && !wr_en_i;
    assign w_addr  = !ready_o ? r_sweep : (wr_en_i ? wr_index_i : lk_index_i);
    assign w_wdata = ready_o ? entry_t'({wr_valid_i, wr_dirty_i, wr_tag_i}) : entry_t'('0);

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign w_we[g] = !ready_o || (w_wr_go && wr_way_i == WAY_W'(g));
        sp_ram #(.DW($bits(entry_t)), .AW(INDEX_AW)) u_ram (
            .clk   (clk),
            .we    (w_we[g]),
            .addr  (w_addr),
            .wdata (w_wdata),
            .rdata (w_rd[g])
        );
    end

    // Descending scan so the lowest matching / invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_all_valid = 1'b1;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_rd[w].valid && w_rd[w].tag == r_lk_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_rd[w].valid) w_inv_way = WAY_W'(w);
            w_all_valid = w_all_valid & w_rd[w].valid;
        end
        w_victim = w_all_valid ? w_repl_way : w_inv_way;
    end

    assign rsp_valid_o    = r_rsp_vld;
    assign hit_o          = r_rsp_vld & w_hit;
    assign hit_way_o      = r_rsp_vld ? w_hit_way : '0;
    assign hit_dirty_o    = r_rsp_vld & w_hit & w_rd[w_hit_way].dirty;
    assign victim_way_o   = r_rsp_vld ? w_victim : '0;
    assign victim_valid_o = r_rsp_vld & w_rd[w_victim].valid;
    assign victim_dirty_o = r_rsp_vld & w_rd[w_victim].dirty;
    assign victim_tag_o   = r_rsp_vld ? w_rd[w_victim].tag : '0;

    if (WAYS == 1) begin : g_norepl
        assign w_repl_way = '0;
    end else begin : g_repl
`ifdef CACHE_TAG_PLRU_EN
        localparam int LVL = $clog2(WAYS);
        logic [INDEX_AW-1:0] r_lk_index;
        logic [WAYS-2:0]     r_plru [DEPTH];
        logic                w_hit_upd, w_wr_upd;
        logic [WAYS-2:0]     w_after_hit, w_wr_base;

        // Node n (heap order, root 1) lives in bit n-1; a 0 bit points the victim at the lower half.
        function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b,
                                                       input logic [WAY_W-1:0] way);
            logic [WAYS-2:0] nb;
            int              node;
            nb   = b;
            node = 1;
            for (int l = LVL - 1; l >= 0; l--) begin
                nb[node-1] = ~way[l];
                node       = 2 * node + int'(way[l]);
            end
            return nb;
        endfunction

        function automatic logic [WAY_W-1:0] plru_leaf(input logic [WAYS-2:0] b);
            int node;
            node = 1;
            for (int l = 0; l < LVL; l++) node = 2 * node + int'(b[node-1]);
            return WAY_W'(node - WAYS);
        endfunction

        assign w_hit_upd   = r_rsp_vld && w_hit;
        assign w_wr_upd    = w_wr_go && wr_valid_i;
        assign w_after_hit = plru_touch(r_plru[r_lk_index], w_hit_way);
        assign w_wr_base   = (w_hit_upd && r_lk_index == wr_index_i) ? w_after_hit
                                                                      : r_plru[wr_index_i];
        assign w_repl_way  = plru_leaf(r_plru[r_lk_index]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lk_index <= '0;
                for (int s = 0; s < DEPTH; s++) r_plru[s] <= '0;
            end else begin
                if (w_lk_go)   r_lk_index <= lk_index_i;
                if (w_hit_upd) r_plru[r_lk_index] <= w_after_hit;
                if (w_wr_upd)  r_plru[wr_index_i] <= plru_touch(w_wr_base, wr_way_i);
            end
        end
`else
        logic [WAY_W-1:0] r_rr_ptr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                   r_rr_ptr <= '0;
            else if (r_rsp_vld && !w_hit && w_all_valid)  r_rr_ptr <= r_rr_ptr + 1'b1;
        end

        assign w_repl_way = r_rr_ptr;
`endif
    end
endmodule
